// File: rtl/serial_multiword_adder_if.sv
// ---------------------------------------------------------------------------
// serial_multiword_adder_if
// Limb-serial stream bundle for serial_multiword_adder.
//   in_valid/in_ready   : input limb handshake (master drives valid)
//   a, b, sub           : operand limbs, LSB limb first; sub read with limb 0
//   out_valid/out_ready : result limb handshake (slave drives valid)
//   r                   : result limb
//   out_last            : r is the final limb of the operand
//   c_out, ovf, zero    : whole-operand flags, valid only with out_last
// master = producer/consumer side (testbench), slave = the adder.
// ---------------------------------------------------------------------------
interface serial_multiword_adder_if #(
    parameter int word_width = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [word_width-1:0] a;
    logic [word_width-1:0] b;
    logic                  sub;
    logic                  out_valid;
    logic                  out_ready;
    logic [word_width-1:0] r;
    logic                  out_last;
    logic                  c_out;
    logic                  ovf;
    logic                  zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, r, out_last, c_out, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, r, out_last, c_out, ovf, zero
    );
endinterface

// File: rtl/serial_multiword_adder.sv
// ---------------------------------------------------------------------------
// serial_multiword_adder
// Adds or subtracts two (word_width*limb_count)-bit operands presented one
// limb per transfer, LSB limb first. One result limb is registered per
// accepted input limb; the final limb carries carry/no-borrow, signed
// overflow and whole-result-zero flags.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_multiword_adder_if.slave (limb streams + flags)
// Also contains fast_adder, the grouped-lookahead limb adder.
// ---------------------------------------------------------------------------

// fast_adder: width-bit adder; carries ripple inside each cascade_size group
// while each group's carry-out is formed by group generate/propagate.
module fast_adder #(
    parameter int width        = 8,
    parameter int cascade_size = 4
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             cin,
    output logic [width-1:0] sum,
    output logic             cout
);
    localparam int NG = (width + cascade_size - 1) / cascade_size;

    logic [width-1:0] g;
    logic [width-1:0] p;
    logic [width:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic gg;
        logic gp;
        int   base;
        int   top;
        c    = '0;
        c[0] = cin;
        gg   = 1'b0;
        gp   = 1'b1;
        base = 0;
        top  = 0;
        for (int k = 0; k < NG; k++) begin
            base = k * cascade_size;
            top  = (base + cascade_size < width) ? base + cascade_size : width;
            gg   = 1'b0;
            gp   = 1'b1;
            for (int j = 0; j < cascade_size; j++) begin
                if (base + j < width) begin
                    c[base+j+1] = g[base+j] | (p[base+j] & c[base+j]);
                    gg          = g[base+j] | (p[base+j] & gg);
                    gp          = gp & p[base+j];
                end
            end
            // group carry-out from lookahead terms (same value as the ripple)
            c[top] = gg | (gp & c[base]);
        end
    end

    assign sum  = p ^ c[width-1:0];
    assign cout = c[width];
endmodule

module serial_multiword_adder #(
    parameter int word_width   = 8,
    parameter int cascade_size = 4,
    parameter int limb_count   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    serial_multiword_adder_if.slave  bus
);
    localparam int IW  = (limb_count > 1) ? $clog2(limb_count) : 1;
    localparam int MSB = word_width - 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(limb_count - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state;
    logic [IW-1:0]         idx;
    logic                  carry;
    logic                  mode;
    logic                  zrun;
    logic [word_width-1:0] r_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic                  c_out_q;
    logic                  ovf_q;
    logic                  zero_q;

    logic                  xfer_in;
    logic                  first;
    logic                  last;
    logic                  mode_eff;
    logic                  cin;
    logic                  cout;
    logic                  zrun_eff;
    logic                  limb_zero;
    logic [word_width-1:0] b_eff;
    logic [word_width-1:0] sum;

    // single-entry output stage: accept whenever the slot is empty or draining
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign xfer_in      = bus.in_valid && bus.in_ready;

    assign first = (state == IDLE);
    assign last  = (idx == LAST_IDX);

    // limb 0 takes mode and carry-in straight from sub; later limbs use state
    assign mode_eff  = first ? bus.sub : mode;
    assign cin       = first ? bus.sub : carry;
    assign b_eff     = mode_eff ? ~bus.b : bus.b;
    assign zrun_eff  = first ? 1'b1 : zrun;
    assign limb_zero = (sum == '0);

    fast_adder #(
        .width        (word_width),
        .cascade_size (cascade_size)
    ) u_add (
        .a    (bus.a),
        .b    (b_eff),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            carry       <= 1'b0;
            mode        <= 1'b0;
            zrun        <= 1'b1;
            r_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            if (xfer_in) begin
                out_valid_q <= 1'b1;
                r_q         <= sum;
                out_last_q  <= last;
                c_out_q     <= last && cout;
                ovf_q       <= last && (bus.a[MSB] == b_eff[MSB]) && (sum[MSB] != bus.a[MSB]);
                zero_q      <= last && zrun_eff && limb_zero;
                carry       <= cout;
                if (first) begin
                    mode <= bus.sub;
                end
                if (last) begin
                    idx   <= '0;
                    state <= IDLE;
                    zrun  <= 1'b1;
                end else begin
                    idx   <= idx + IW'(1);
                    state <= RUN;
                    zrun  <= zrun_eff && limb_zero;
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.r         = r_q;
    assign bus.out_last  = out_last_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_serial_multiword_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_multiword_adder
// Directed vectors with hand-computed results, a stall, a mid-operand reset,
// back-to-back operands, then random operands against a 32-bit model.
// A negedge monitor pops expected limbs on every output transfer.
// ---------------------------------------------------------------------------
module tb_serial_multiword_adder;
    localparam int WW = 8;
    localparam int LC = 4;
    localparam int CS = 4;

    typedef struct {
        logic [7:0] r;
        logic       last;
        logic       cout;
        logic       ovf;
        logic       zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    bit   rnd_rdy = 1'b0;

    serial_multiword_adder_if #(.word_width(WW)) bus ();

    serial_multiword_adder #(
        .word_width   (WW),
        .cascade_size (CS),
        .limb_count   (LC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    function automatic void push_limb(input logic [7:0] r, input logic last, cout, ovf, zero);
        exp_t e;
        e.r = r; e.last = last; e.cout = cout; e.ovf = ovf; e.zero = zero;
        expq.push_back(e);
    endfunction

    // hand-computed 32-bit result and final flags
    function automatic void exp_hand(input logic [31:0] r, input logic cout, ovf, zero);
        for (int i = 0; i < LC; i++)
            push_limb(r[8*i +: 8], i == LC-1, (i == LC-1) && cout, (i == LC-1) && ovf, (i == LC-1) && zero);
    endfunction

    // whole-operand reference for random operands
    function automatic void push_model(input logic [31:0] a, b, input logic s);
        logic [32:0] t;
        logic        v;
        if (s) begin
            t = {1'b0, a} + {1'b0, ~b} + 33'd1;
            v = (a[31] != b[31]) && (t[31] != a[31]);
        end else begin
            t = {1'b0, a} + {1'b0, b};
            v = (a[31] == b[31]) && (t[31] != a[31]);
        end
        exp_hand(t[31:0], t[32], v, t[31:0] == 32'd0);
    endfunction

    // present one limb; returns at posedge+1 after it was accepted
    task automatic drive_limb(input logic [7:0] a, b, input logic s, output int waits);
        bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.sub = s;
        waits = 0;
        @(negedge clk);
        while (!bus.in_ready && waits <= 200) begin
            waits++;
            @(negedge clk);
        end
        if (waits > 200) chk("drv_timeout", 1, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // noise: 0 keep sub, 1 invert sub on limbs 1.., 2 random sub on limbs 1..
    task automatic send_op(input logic [31:0] a, b, input logic s, input int noise,
                           input bit gaps, output int tw);
        int   w;
        logic sl;
        tw = 0;
        for (int i = 0; i < LC; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            sl = s;
            if (i > 0 && noise == 1) sl = ~s;
            if (i > 0 && noise == 2) sl = 1'($urandom_range(0, 1));
            drive_limb(a[8*i +: 8], b[8*i +: 8], sl, w);
            tw += w;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (expq.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", expq.size(), 0);
    endtask

    // output monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    chk("extra_limb", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("r", bus.r, e.r);
                    chk("out_last", bus.out_last, e.last);
                    chk("c_out", bus.c_out, e.cout);
                    chk("ovf", bus.ovf, e.ovf);
                    chk("zero", bus.zero, e.zero);
                end
            end
        end
    end

    // random back-pressure
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          tw;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic [7:0]  lat_r [LC] = '{8'h00, 8'h01, 8'h00, 8'h00};
        logic [31:0] op_a  = 32'h000000FF;
        logic [31:0] op_b  = 32'h00000001;

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_r", bus.r, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_c_out", bus.c_out, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_zero", bus.zero, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rel_in_ready", bus.in_ready, 1);

        // 0xFF + 1, with one-cycle latency check on each limb
        exp_hand(32'h00000100, 0, 0, 0);
        for (int i = 0; i < LC; i++) begin
            drive_limb(op_a[8*i +: 8], op_b[8*i +: 8], 1'b0, w);
            @(negedge clk);
            chk("lat_vld", bus.out_valid, 1);
            chk("lat_r", bus.r, lat_r[i]);
            @(posedge clk); #1;
        end
        wait_drain();

        // all-ones + 1: carry out, zero result
        exp_hand(32'h00000000, 1, 0, 1);
        send_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0, tw);
        wait_drain();

        // 0x80000000 - 1 with sub toggled on limbs 1..3
        exp_hand(32'h7FFFFFFF, 1, 1, 0);
        send_op(32'h80000000, 32'h00000001, 1'b1, 1, 1'b0, tw);
        wait_drain();

        // back-to-back, no bubbles with out_ready high
        exp_hand(32'h23456789, 0, 0, 0);
        exp_hand(32'hFFFFFFFE, 0, 0, 0);
        exp_hand(32'h80000000, 0, 1, 0);
        send_op(32'h12345678, 32'h11111111, 1'b0, 0, 1'b0, tw);
        chk("b2b_wait0", tw, 0);
        send_op(32'h00000005, 32'h00000007, 1'b1, 0, 1'b0, tw);
        chk("b2b_wait1", tw, 0);
        send_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 1'b0, tw);
        chk("b2b_wait2", tw, 0);
        wait_drain();

        // stall for 3 cycles after limb 1 of 0x01FFFF80 + 0x00000180
        exp_hand(32'h02000100, 0, 0, 0);
        drive_limb(8'h80, 8'h80, 1'b0, w);
        drive_limb(8'hFF, 8'h01, 1'b0, w);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.a = 8'hFF; bus.b = 8'h00; bus.sub = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_out_valid", bus.out_valid, 1);
            chk("stall_r", bus.r, 8'h01);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        drive_limb(8'hFF, 8'h00, 1'b0, w);
        drive_limb(8'h01, 8'h00, 1'b0, w);
        wait_drain();

        // reset after limb 1 of 0xFF + 1, then 2 + 3
        push_limb(8'h00, 0, 0, 0, 0);
        push_limb(8'h01, 0, 0, 0, 0);
        drive_limb(8'hFF, 8'h01, 1'b0, w);
        drive_limb(8'h00, 8'h00, 1'b0, w);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_r", bus.r, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        expq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_hand(32'h00000005, 0, 0, 0);
        send_op(32'h00000002, 32'h00000003, 1'b0, 0, 1'b0, tw);
        wait_drain();

        // random operands, random gaps and back-pressure
        rnd_rdy = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (n % 50 == 0) rb = ra;
            push_model(ra, rb, rs);
            send_op(ra, rb, rs, 2, 1'b1, tw);
        end
        rnd_rdy = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
